mult_div_unit: RTL and testbench

- Iterative HI/LO multiply/divide unit for the MIPS datapath. Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the single-cycle ALU and owns the architectural HI/LO registers.
- Multiply uses radix-2 shift-add; divide uses restoring shift-subtract, one bit per cycle.
- The decoder stalls dependent MFHI/MFLO on busy.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mult_div_unit.sv | 135 +++++++++++++
 tb/tb_mult_div_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative HI/LO multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    localparam logic [2:0] NOP_CODE_A = 3'd6;
    localparam logic [2:0] NOP_CODE_B = 3'd7;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI/LO registers.
//   state | meaning
//   IDLE  | waiting; accepts MULT/DIV variants and MTHI/MTLO
//   CALC  | one shift-add / shift-subtract step per cycle on magnitudes
//   FIX   | sign correction, HI/LO written at the following edge
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t         state, state_nxt;
    mdu_op_t            op_in, op_q;
    logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
    logic [WIDTH-1:0]   opd, a_mag, b_mag, q_fix, r_fix, hi_fix, lo_fix;
    logic [WIDTH:0]     as_a, as_b, as_sum;
    logic [CW-1:0]      cnt;
    logic               neg_a, neg_b, done_q;
    logic               is_iter_in, signed_in, a_neg_in, b_neg_in, is_mul;

    assign op_in      = mdu_op_t'(op);
    assign is_iter_in = (op[2] == 1'b0);
    assign signed_in  = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign a_neg_in   = signed_in && op_a[WIDTH-1];
    assign b_neg_in   = signed_in && op_b[WIDTH-1];
    assign a_mag      = a_neg_in ? -op_a : op_a;
    assign b_mag      = b_neg_in ? -op_b : op_b;
    assign is_mul     = (op_q == OP_MULT) || (op_q == OP_MULTU);

    // Shared adder: adds the multiplicand, or subtracts the divisor from the shifted remainder.
    assign as_a   = is_mul ? {1'b0, acc[2*WIDTH-1:WIDTH]} : acc[2*WIDTH-1:WIDTH-1];
    assign as_b   = is_mul ? {1'b0, opd} : ~{1'b0, opd};
    assign as_sum = as_a + as_b + {{WIDTH{1'b0}}, ~is_mul};

    always_comb begin
        acc_step = acc;
        if (is_mul) begin
            acc_step = acc[0] ? {as_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        end else if (!as_sum[WIDTH]) begin
            acc_step = {as_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    // A zero divisor leaves the quotient at all ones, so it must not be negated.
    always_comb begin
        prod_fix = acc;
        q_fix    = acc[WIDTH-1:0];
        r_fix    = acc[2*WIDTH-1:WIDTH];
        if ((op_q == OP_MULT) && (neg_a ^ neg_b))
            prod_fix = -acc;
        if ((op_q == OP_DIV) && (neg_a ^ neg_b) && (opd != '0))
            q_fix = -acc[WIDTH-1:0];
        if ((op_q == OP_DIV) && neg_a)
            r_fix = -acc[2*WIDTH-1:WIDTH];
        hi_fix = is_mul ? prod_fix[2*WIDTH-1:WIDTH] : r_fix;
        lo_fix = is_mul ? prod_fix[WIDTH-1:0] : q_fix;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && is_iter_in) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            opd    <= '0;
            op_q   <= OP_MULT;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_iter_in) begin
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            opd   <= b_mag;
                            op_q  <= op_in;
                            neg_a <= a_neg_in;
                            neg_b <= b_neg_in;
                            cnt   <= CW'(WIDTH-1);
                        end else if (op_in == OP_MTHI) begin
                            hi <= op_a;
                        end else if (op_in == OP_MTLO) begin
                            lo <= op_a;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                FIX: begin
                    hi <= hi_fix;
                    lo <= lo_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against a 64-bit arithmetic reference.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int total  = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: begin sq = sa * sb; return sq; end
            3'd1: begin uq = ua * ub; return uq; end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Called at a falling edge; returns just after the acceptance edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    // Returns at the falling edge of the done cycle.
    task automatic wait_result(input string tag, input logic [31:0] ehi, input logic [31:0] elo, input int elat);
        int lat;
        bit busy_ok;
        busy_ok = 1'b1;
        for (lat = 0; lat < 100; lat++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
        end
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, ".hi"}, 64'(hi), 64'(ehi));
        check({tag, ".lo"}, 64'(lo), 64'(elo));
        check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] exp;
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        bit          seen_done;

        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        op_a  = '0;
        op_b  = '0;
        #2;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(3'd4, 32'h0000_1234, $urandom);
        @(negedge clk);
        check("mthi.hi", 64'(hi), 64'h1234);
        check("mthi.lo", 64'(lo), 64'd0);
        check("mthi.busy", 64'(busy), 64'd0);
        check("mthi.done", 64'(done), 64'd0);

        issue(3'd5, 32'h5678_9ABC, $urandom);
        @(negedge clk);
        check("mtlo.lo", 64'(lo), 64'h5678_9ABC);
        check("mtlo.hi", 64'(hi), 64'h1234);

        issue(3'd6, 32'hFFFF_0000, 32'h1);
        @(negedge clk);
        issue(3'd7, 32'h0F0F_0F0F, 32'h2);
        @(negedge clk);
        check("nop.hilo", {hi, lo}, 64'h0000_1234_5678_9ABC);
        check("nop.busy", 64'(busy), 64'd0);

        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        wait_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 33);
        issue(3'd0, 32'd2, 32'd3);
        wait_result("mult_b2b", 32'd0, 32'd6, 33);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        issue(3'd3, 32'd7, 32'd2);
        wait_result("divu", 32'd1, 32'd3, 33);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 32'd0, 32'h8000_0000, 33);
        issue(3'd3, 32'd5, 32'd0);
        wait_result("divu_zero", 32'd5, 32'hFFFF_FFFF, 33);
        issue(3'd2, 32'hFFFF_FFF6, 32'd0);
        wait_result("div_zero_neg", 32'hFFFF_FFF6, 32'hFFFF_FFFF, 33);

        // MTLO then MTHI requested while a divide is in flight must be dropped.
        issue(3'd3, 32'd1000, 32'd10);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 3'd5;
        op_a  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        op    = 3'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result("mtx_busy", 32'd0, 32'd100, 27);

        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            exp = model(ro, ra, rb);
            issue(ro, ra, rb);
            wait_result($sformatf("rand%0d_op%0d", i, ro), exp[63:32], exp[31:0], 33);
        end

        // Abort a divide mid-flight with reset; no result or done may follow.
        issue(3'd3, 32'd5, 32'd0);
        wait_result("pre_abort", 32'd5, 32'hFFFF_FFFF, 33);
        issue(3'd2, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.hi", 64'(hi), 64'd0);
        check("abort.lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("abort.no_done", 64'(seen_done), 64'd0);
        check("abort.idle_busy", 64'(busy), 64'd0);
        check("abort.hilo_kept", {hi, lo}, 64'd0);

        issue(3'd3, 32'd100, 32'd7);
        wait_result("post_abort", 32'd2, 32'hE, 33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
